// File: rtl/window_3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator and the filter stage
// that consumes its taps.
package window_3x3_gen_pkg;

  localparam int PIX_W = 8;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;
  localparam int NTAP   = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
interface window_3x3_gen_if
  import window_3x3_gen_pkg::*;
#(
  parameter int WIDTH  = 200,
  parameter int HEIGHT = 200
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [PIX_W-1:0]      pix_in;
  logic                  pix_valid;
  logic                  pix_sof;
  logic                  pix_ready;
  logic [NTAP*PIX_W-1:0] win_out;
  logic                  win_valid;
  logic [XW-1:0]         win_x;
  logic [YW-1:0]         win_y;
  logic                  frame_done;

  modport master (
    output pix_in, pix_valid, pix_sof,
    input  pix_ready,
    input  win_out, win_valid, win_x, win_y, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof,
    output pix_ready,
    output win_out, win_valid, win_x, win_y, frame_done
  );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// Circular one-line delay: output is the pixel written DEPTH shifts ago.
module line_buffer
  import window_3x3_gen_pkg::*;
#(
  parameter int DEPTH = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q + AW'(1);
    if (ptr_q == AW'(DEPTH - 1)) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (shift_i) ptr_q <= ptr_d;
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (shift_i) mem_q[ptr_q] <= din_i;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator; window centre lags the newest
// pixel by one line plus one, with zero padding outside the image.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int WIDTH  = 200,
  parameter int HEIGHT = 200
) (
  input logic             clk,
  input logic             rst,
  window_3x3_gen_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int FW = $clog2(WIDTH + 2);
  localparam logic [FW-1:0] FILL = FW'(WIDTH + 1);

  state_t state_q, state_d;
  logic [XW-1:0] ix_q, ix_d, ox_q, ox_d, wx_q;
  logic [YW-1:0] iy_q, iy_d, oy_q, oy_d, wy_q;
  logic [FW-1:0] fill_q, fill_d, flu_q, flu_d;
  logic step, sof_step, fire, last_out;
  logic wvalid_q, done_q;
  logic [PIX_W-1:0] pix, lb0_o, lb1_o;
  logic [PIX_W-1:0] win_q [NTAP];
  logic [PIX_W-1:0] win_d [NTAP];
  logic [NTAP*PIX_W-1:0] wout_q, wout_d;

  assign bus.pix_ready  = (state_q != FLUSH);
  assign bus.win_out    = wout_q;
  assign bus.win_valid  = wvalid_q;
  assign bus.win_x      = wx_q;
  assign bus.win_y      = wy_q;
  assign bus.frame_done = done_q;

  line_buffer #(.DEPTH(WIDTH)) u_lb0 (
    .clk, .rst, .shift_i(step), .din_i(pix), .dout_o(lb0_o)
  );
  line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk, .rst, .shift_i(step), .din_i(lb0_o), .dout_o(lb1_o)
  );

  always_comb begin
    state_d  = state_q;
    ix_d     = ix_q;
    iy_d     = iy_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    fill_d   = fill_q;
    flu_d    = flu_q;
    step     = 1'b0;
    sof_step = 1'b0;
    pix      = bus.pix_in;
    unique case (state_q)
      IDLE: begin
        step     = bus.pix_valid && bus.pix_sof;
        sof_step = step;
      end
      RUN: begin
        step     = bus.pix_valid;
        sof_step = bus.pix_valid && bus.pix_sof;
      end
      FLUSH: begin
        step = 1'b1;
        pix  = '0;
      end
      default: state_d = IDLE;
    endcase
    fire     = step && !sof_step && (fill_q == FILL);
    last_out = (ox_q == XW'(WIDTH - 1)) &&
               (oy_q == YW'(HEIGHT - 1));
    // sof restarts both counter pairs; this pixel is (0,0)
    if (sof_step) begin
      state_d = RUN;
      ix_d    = XW'(1);
      iy_d    = '0;
      ox_d    = '0;
      oy_d    = '0;
      fill_d  = FW'(1);
    end else if (step) begin
      if (fill_q != FILL) fill_d = fill_q + FW'(1);
      if (state_q == RUN) begin
        if (ix_q == XW'(WIDTH - 1)) begin
          ix_d = '0;
          if (iy_q == YW'(HEIGHT - 1)) begin
            iy_d    = '0;
            flu_d   = '0;
            state_d = FLUSH;
          end else begin
            iy_d = iy_q + YW'(1);
          end
        end else begin
          ix_d = ix_q + XW'(1);
        end
      end else if (flu_q == FW'(WIDTH)) begin
        flu_d   = '0;
        state_d = IDLE;
      end else begin
        flu_d = flu_q + FW'(1);
      end
      if (fire) begin
        if (ox_q == XW'(WIDTH - 1)) begin
          ox_d = '0;
          oy_d = last_out ? '0 : oy_q + YW'(1);
        end else begin
          ox_d = ox_q + XW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]     = win_q[3*r+1];
      win_d[3*r + 1] = win_q[3*r+2];
    end
    win_d[TAP_NE] = lb1_o;
    win_d[TAP_E]  = lb0_o;
    win_d[TAP_SE] = pix;
  end

  always_comb begin
    wout_d = '0;
    for (int k = 0; k < NTAP; k++) begin
      if (!((k % 3 == 0 && ox_q == '0) ||
            (k % 3 == 2 && ox_q == XW'(WIDTH - 1)) ||
            (k <= TAP_NE && oy_q == '0) ||
            (k >= TAP_SW && oy_q == YW'(HEIGHT - 1))))
        wout_d[PIX_W*k +: PIX_W] = win_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ix_q     <= '0;
      iy_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      fill_q   <= '0;
      flu_q    <= '0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      wout_q   <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
      for (int k = 0; k < NTAP; k++) win_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      fill_q   <= fill_d;
      flu_q    <= flu_d;
      wvalid_q <= fire;
      done_q   <= fire && last_out;
      if (step) begin
        for (int k = 0; k < NTAP; k++) win_q[k] <= win_d[k];
      end
      if (fire) begin
        wout_q <= wout_d;
        wx_q   <= ox_q;
        wy_q   <= oy_q;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x3 image.
module tb_window_3x3_gen;
  import window_3x3_gen_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  window_3x3_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         x;
    int         y;
    logic [71:0] w;
    logic       done;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  img [H][W];
  logic [71:0] got [H][W];
  int nvec   = 0;
  int nerr   = 0;
  int ndone  = 0;
  int done_x = -1;
  int done_y = -1;
  int lowrun = 0;

  task automatic chk(string name, logic [71:0] act,
                     logic [71:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // zero-padded neighbourhood taken straight from the image
  function automatic logic [71:0] exp_win(int cx, int cy);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int x;
        int y;
        x = cx + c - 1;
        y = cy + r - 1;
        if (x >= 0 && x < W && y >= 0 && y < H)
          w[8*(3*r+c) +: 8] = img[y][x];
      end
    end
    return w;
  endfunction

  task automatic push_windows(int n, bit full);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.x    = i % W;
      e.y    = i / W;
      e.w    = exp_win(e.x, e.y);
      e.done = full && (i == W*H - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic fill_img(int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       img[y][x] = 8'(16*y + x);
          1:       img[y][x] = ~8'(16*y + x);
          default: img[y][x] = 8'($urandom);
        endcase
  endtask

  task automatic step_pix(logic [7:0] p, logic sof);
    int t;
    t = 0;
    bus.pix_in    = p;
    bus.pix_sof   = sof;
    bus.pix_valid = 1'b1;
    while (bus.pix_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      nvec++;
      nerr++;
      $display("FAIL ready_timeout: got ready=0, expected 1");
    end
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic send_pixels(int npix, bit gap);
    for (int i = 0; i < npix; i++) begin
      step_pix(img[i/W][i%W], i == 0);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_left", 72'(sbq.size()), 72'(0));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.frame_done === 1'b1 && bus.win_valid !== 1'b1)
      chk("done_without_valid", 72'(bus.win_valid), 72'(1));
    if (bus.win_valid === 1'b1) begin
      if (bus.frame_done === 1'b1) begin
        ndone++;
        done_x = int'(bus.win_x);
        done_y = int'(bus.win_y);
      end
      if (int'(bus.win_y) < H)
        got[bus.win_y][bus.win_x] = bus.win_out;
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_window: got (%0d,%0d), expected none",
                 bus.win_x, bus.win_y);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("win_out(%0d,%0d)", e.x, e.y),
            bus.win_out, e.w);
        chk($sformatf("win_x(%0d,%0d)", e.x, e.y),
            72'(bus.win_x), 72'(e.x));
        chk($sformatf("win_y(%0d,%0d)", e.x, e.y),
            72'(bus.win_y), 72'(e.y));
        chk($sformatf("done(%0d,%0d)", e.x, e.y),
            72'(bus.frame_done), 72'(e.done));
      end
    end
  end

  always @(negedge clk) begin : ready_watch
    if (!rst) begin
      if (bus.pix_ready === 1'b0) begin
        lowrun++;
      end else if (lowrun != 0) begin
        chk("ready_low_cycles", 72'(lowrun), 72'(W + 1));
        lowrun = 0;
      end
    end
  end

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_win_valid", 72'(bus.win_valid), 72'(0));
    chk("rst_win_out", bus.win_out, 72'(0));
    chk("rst_win_x", 72'(bus.win_x), 72'(0));
    chk("rst_win_y", 72'(bus.win_y), 72'(0));
    chk("rst_frame_done", 72'(bus.frame_done), 72'(0));
    chk("rst_pix_ready", 72'(bus.pix_ready), 72'(1));

    fill_img(0);
    push_windows(W*H, 1'b1);
    send_pixels(W*H, 1'b0);
    drain();
    chk("hand_win_1_1", got[1][1], 72'h22_21_20_12_11_10_02_01_00);
    chk("hand_win_0_0", got[0][0], 72'h11_10_00_01_00_00_00_00_00);
    chk("hand_done_x", 72'(done_x), 72'(3));
    chk("hand_done_y", 72'(done_y), 72'(2));

    // gapped frame, then inverted frame straight after its flush
    push_windows(W*H, 1'b1);
    send_pixels(W*H, 1'b1);
    fill_img(1);
    push_windows(W*H, 1'b1);
    send_pixels(W*H, 1'b0);
    drain();
    chk("inv_win_0_0", got[0][0], 72'hEE_EF_00_FE_FF_00_00_00_00);
    chk("done_after_3", 72'(ndone), 72'(3));

    // abort: sof on pixel 6 starts a new frame
    fill_img(2);
    push_windows(1, 1'b0);
    send_pixels(6, 1'b0);
    fill_img(2);
    push_windows(W*H, 1'b1);
    send_pixels(W*H, 1'b0);
    drain();
    chk("done_after_abort", 72'(ndone), 72'(4));

    // reset during pixel 7
    fill_img(2);
    push_windows(2, 1'b0);
    send_pixels(7, 1'b0);
    bus.pix_in    = img[1][3];
    bus.pix_valid = 1'b1;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    chk("valid_after_rst", 72'(bus.win_valid), 72'(0));
    chk("drain_before_rst", 72'(sbq.size()), 72'(0));
    for (int i = 0; i < 3; i++) begin
      bus.pix_in    = 8'(8'h55 + i);
      bus.pix_valid = 1'b1;
      bus.pix_sof   = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.pix_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    fill_img(2);
    push_windows(W*H, 1'b1);
    send_pixels(W*H, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("frames_done_total", 72'(ndone), 72'(5));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the convolution/filter stage. It accepts one RGB332 pixel per cycle in raster order. For every image position it emits the 9 neighbourhood pixels, tap 0 at (−1,−1) through tap 8 at (+1,+1), with zero padding outside the image. It uses two internal line buffers, so the filter stage reads one pixel stream instead of nine replicated image ROMs.

## Interface
- WIDTH, 200: image width in pixels (≥3)
- HEIGHT, 200: image height in lines (≥2)
- clk  in  1: pixel clock (the 25 MHz VGA clock)
- rst  in  1: synchronous, active-high reset
- pix_in  in  8: RGB332 pixel, r[7:5] g[4:2] b[1:0]
- pix_valid  in  1: pix_in valid
- pix_sof  in  1: qualifies the first pixel of a frame; meaningful only with pix_valid
- pix_ready  out  1: block accepts a pixel this cycle
- win_out  out  72: tap k at [8k+7:8k], k = 3·row + col; row 0 = cy−1, col 0 = cx−1
- win_valid  out  1: win_out, win_x and win_y valid (no backpressure; the consumer must take it)
- win_x  out  $clog2(WIDTH): centre column cx
- win_y  out  $clog2(HEIGHT): centre line cy
- frame_done  out  1: one-cycle pulse with the last window of a frame

## Operation
- States:
  - IDLE: pix_ready=1. Pixels without pix_sof are dropped. An accepted pixel with pix_sof goes to RUN as pixel (0,0).
  - RUN: pix_ready=1. Each accepted pixel is one step. Input counters in_x/in_y wrap at WIDTH/HEIGHT. Accepting pixel (WIDTH−1, HEIGHT−1) goes to FLUSH.
  - FLUSH: pix_ready=0. One step per cycle with internal pixel 0. After WIDTH+1 flush steps, go to IDLE.
- pix_sof in RUN: abort the current frame. No further windows from it and no frame_done. The pixel becomes (0,0) of the new frame, and the output counters restart.
- Datapath per step:
  - 3x3 register array shifts left one column.
  - New right column = {line_buf1 out, line_buf0 out, pixel}.
  - line_buf0 is written with the pixel; line_buf1 is written with the line_buf0 output.
- The window centre lags the newest pixel by WIDTH+1 steps. Step index n (0-based in the frame) produces centre index n−WIDTH−1, valid for WIDTH+1 ≤ n ≤ WIDTH·HEIGHT+WIDTH. This gives exactly WIDTH·HEIGHT windows per frame.
- Masking is on output centre (cx,cy):
  - cx=0 zeroes col 0; cx=WIDTH−1 zeroes col 2.
  - cy=0 zeroes row 0; cy=HEIGHT−1 zeroes row 2.
  - Stale line-buffer data is never visible.
- Window order is raster. win_x/win_y come from output counters that are independent of the input counters.

## Timing
- win_out, win_valid, win_x, win_y and frame_done are registered. They update the cycle after the step that completes the window.
- Latency from accepting pixel (x,y) to the window centred on (x−1,y−1) is 1 cycle.
- Throughput is 1 window/cycle with continuous input.
  - Gaps in pix_valid stall all state; win_valid=0 during a gap.
  - FLUSH runs at full rate for WIDTH+1 cycles regardless of pix_valid.
- pix_ready is combinational from state (=0 only in FLUSH).
- Pixel and window throughput are equal, so no input throttling is needed beyond FLUSH.
- Reset values:
  - state IDLE, all counters 0.
  - win_valid 0, win_out 0, win_x 0, win_y 0, frame_done 0; pix_ready 1.
  - Line-buffer RAM is not cleared.
- Reset mid-frame: the next cycle is IDLE with no windows. The first window after a new pix_sof is the masked (0,0) window.

## Structure
- The shared package holds:
  - PIX_W=8.
  - RGB332 field positions for r, g and b.
  - The tap index constants TAP_NW…TAP_SE (0…8), shared with the filter stage's kernel indexing.
  - The state enum {IDLE, RUN, FLUSH}.
- Sub-module line_buffer (parameter DEPTH=WIDTH, 8-bit):
  - Single circular pointer advanced on shift enable.
  - Read-before-write at the same address, so the output is the value written DEPTH shifts earlier.
  - Instantiated twice.

## Test plan
- WIDTH=4, HEIGHT=3, pixel value = 16·y+x, continuous stream with pix_sof on the first pixel:
  - Expect 12 windows in raster order.
  - Window (1,1): taps 00,01,02,10,11,12,20,21,22 (hex).
  - Window (0,0): taps 0,0,0,0,00,01,0,10,11.
  - frame_done with (3,2).
  - pix_ready low for exactly 5 cycles.
- Same frame with pix_valid low every other cycle: identical windows in the same order, with win_valid only on step cycles.
- Second frame starting right after FLUSH with inverted pixel data: window (0,0) row 0 and col 0 are zero (no leakage from the previous frame); 12 windows.
- pix_sof reasserted at pixel 6 of a frame: no frame_done for the aborted frame; the next windows start at (0,0) of the new frame.
- rst asserted at pixel 7 (one cycle): win_valid=0 next cycle; pixels without pix_sof are ignored until pix_sof is seen.
- Default WIDTH=200, HEIGHT=200, random pixels vs. reference model: 40000 windows, all taps match, frame_done exactly once at (199,199).
